spi_responder: RTL and testbench

- SPI target (slave) for the extension board's SPI port, i.e. the far end of the SCK/MOSI/MISO/nSS lines driven by the Gigatron ctrl-code master.
- Oversamples SPI in the CLK domain and decodes a byte command protocol.
- Bridges the decoded commands to a byte-wide local register bus.
- Used as a board peripheral and as the bench counterpart for the master.

---
 rtl/spi_responder.sv | 172 +++++++++++++++++
 tb/tb_spi_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_responder.sv
// spi_responder: SPI target (CPHA=0) oversampled in the CLK domain. Decodes a
// byte command protocol (0x02 write, 0x03 read, optional 0x9F ID) and bridges
// it onto a byte-wide local register bus with one-CLK WE/RD strobes.
// Optional feature macro: SPI_RESP_ID_EN enables the 0x9F ID command.
`timescale 1ns/1ps
module spi_responder #(
  parameter bit         CPOL  = 1'b0,
  parameter logic [7:0] ID_HI = 8'hC5,
  parameter logic [7:0] ID_LO = 8'h01
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       nSS,
  output logic       MISO,
  output logic       MISO_OE,
  output logic [7:0] ADDR,
  output logic [7:0] WDATA,
  output logic       WE,
  output logic       RD,
  input  logic [7:0] RDATA
);

  typedef enum logic [2:0] {
    IDLE, CMD, WADDR, RADDR, WDAT, RDAT, ID, IGNORE
  } state_t;

  state_t state, state_next;

  // Synchroniser stages: _p0 first flop, _p1 synced, _p2 previous synced SCK
  logic sck_p0, sck_p1, sck_p2;
  logic mosi_p0, mosi_p1;
  logic nss_p0, nss_p1;

  logic       sel;
  logic       lead, trail;
  logic       active;
  logic       byte_done;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] rx_byte;
  logic [7:0] tx;
  logic       armed;
  logic       rd_pend;
  logic       id_second;
  logic       we_next, rd_next;

  // Two-flop synchronisers on the SPI pins plus one delay for SCK edge detect
  always_ff @(posedge CLK) begin
    sck_p0  <= SCK;
    sck_p1  <= sck_p0;
    sck_p2  <= sck_p1;
    mosi_p0 <= MOSI;
    mosi_p1 <= mosi_p0;
    nss_p0  <= nSS;
    nss_p1  <= nss_p0;
  end

  assign sel       = ~nss_p1;
  assign lead      = CPOL ? (~sck_p1 & sck_p2) : (sck_p1 & ~sck_p2);
  assign trail     = CPOL ? (sck_p1 & ~sck_p2) : (~sck_p1 & sck_p2);
  assign active    = (state != IDLE);
  // A byte completing in the same CLK that nSS rises still counts as complete
  assign byte_done = active && lead && (cnt == 3'd7);
  assign rx_byte   = {rx, mosi_p1};

  // State register
  always_ff @(posedge CLK) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode and strobe generation
  always_comb begin
    state_next = state;
    we_next    = 1'b0;
    rd_next    = 1'b0;
    case (state)
      // Entering a frame is only legal once nSS has been seen high since reset
      IDLE: if (sel) state_next = armed ? CMD : IGNORE;
      CMD: begin
        if (byte_done) begin
          case (rx_byte)
            8'h02:   state_next = WADDR;
            8'h03:   state_next = RADDR;
`ifdef SPI_RESP_ID_EN
            8'h9F:   state_next = ID;
`endif
            default: state_next = IGNORE;
          endcase
        end
      end
      WADDR: if (byte_done) state_next = WDAT;
      RADDR: begin
        if (byte_done) begin
          state_next = RDAT;
          rd_next    = 1'b1;
        end
      end
      WDAT:    we_next = byte_done;
      default: state_next = state;
    endcase
    // Prefetch for the next read byte, one CLK after the address bump
    if (rd_pend && sel) rd_next = 1'b1;
    if (!sel) state_next = IDLE;
  end

  // Bit counter, framing flags and bus strobes
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      cnt       <= 3'd0;
      armed     <= 1'b0;
      rd_pend   <= 1'b0;
      id_second <= 1'b0;
      WE        <= 1'b0;
      RD        <= 1'b0;
      MISO_OE   <= 1'b0;
    end else begin
      if (!sel || state == IDLE) cnt <= 3'd0;
      else if (lead)             cnt <= cnt + 3'd1;
      if (!sel) armed <= 1'b1;
      rd_pend <= byte_done && (state == RDAT);
      if (state == CMD)                   id_second <= 1'b0;
      else if (byte_done && state == ID)  id_second <= 1'b1;
      WE      <= we_next;
      RD      <= rd_next;
      MISO_OE <= sel;
    end
  end

  // Local bus address and write data
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      ADDR  <= 8'h00;
      WDATA <= 8'h00;
    end else begin
      if (byte_done && (state == WADDR || state == RADDR)) ADDR <= rx_byte;
      else if (WE)                                          ADDR <= ADDR + 8'd1;
      else if (byte_done && state == RDAT)                  ADDR <= ADDR + 8'd1;
      if (byte_done && state == WDAT) WDATA <= rx_byte;
    end
  end

  // Receive shifter, sampled on leading edges
  always_ff @(posedge CLK) begin
    if (active && lead) rx <= {rx[5:0], mosi_p1};
  end

  // Transmit byte: zeros, ID bytes or prefetched read data
  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      tx <= 8'h00;
    end else if (RD) begin
      tx <= RDATA;
    end else if (byte_done) begin
      if (state_next == ID && state == CMD) tx <= ID_HI;
      else if (state == ID)                 tx <= id_second ? 8'h00 : ID_LO;
      else                                  tx <= 8'h00;
    end
  end

  // MISO: bit 7 ready at select, then next bit on each trailing edge
  always_ff @(posedge CLK) begin
    if (!nRESET)              MISO <= 1'b1;
    else if (!sel)            MISO <= 1'b1;
    else if (state == IDLE)   MISO <= ~armed;
    else if (state == IGNORE) MISO <= 1'b1;
    else if (trail)           MISO <= tx[~cnt];
  end

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed SPI master vectors against spi_responder with a
// bench-side register memory and strobe monitor.
`timescale 1ns/1ps
module tb_spi_responder;

  localparam int HALF = 60;

  logic       CLK = 1'b0;
  logic       nRESET, SCK, MOSI, nSS;
  logic       MISO, MISO_OE, WE, RD;
  logic [7:0] ADDR, WDATA, RDATA;

  logic [7:0] mem [256];
  logic [7:0] we_addr [64];
  logic [7:0] we_data [64];
  logic [7:0] rd_addr [64];
  int n_we = 0, n_rd = 0, n_both = 0;
  int n_vec = 0, n_bad = 0;

  spi_responder dut (
    .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
    .MISO(MISO), .MISO_OE(MISO_OE), .ADDR(ADDR), .WDATA(WDATA),
    .WE(WE), .RD(RD), .RDATA(RDATA)
  );

  always #5 CLK = ~CLK;

  assign RDATA = mem[ADDR];

  always @(negedge CLK) begin
    if (WE) begin
      if (n_we < 64) begin
        we_addr[n_we] <= ADDR;
        we_data[n_we] <= WDATA;
      end
      n_we <= n_we + 1;
    end
    if (RD) begin
      if (n_rd < 64) rd_addr[n_rd] <= ADDR;
      n_rd <= n_rd + 1;
    end
    if (WE && RD) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] d, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = d[i];
      #(HALF);
      r[i] = MISO;
      SCK = 1'b1;
      #(HALF);
      SCK = 1'b0;
    end
  endtask

  task automatic sel_low();
    @(negedge CLK);
    nSS = 1'b0;
    #(HALF);
  endtask

  task automatic sel_high();
    #(HALF);
    nSS = 1'b1;
    repeat (20) @(negedge CLK);
  endtask

  logic [7:0] r0, r1, r2, r3;
  int bw, br;

  initial begin
    nRESET = 1'b0; SCK = 1'b0; MOSI = 1'b0; nSS = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C; mem[8'h21] = 8'h81;
    mem[8'hFF] = 8'h5A; mem[8'h00] = 8'hA5;
    repeat (5) @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    check("rst_miso", MISO, 1'b1);
    check("rst_oe", MISO_OE, 1'b0);
    check("rst_addr", ADDR, 8'h00);
    check("rst_wdata", WDATA, 8'h00);
    check("rst_we", WE, 1'b0);
    check("rst_rd", RD, 1'b0);
    repeat (5) @(negedge CLK);

    // Write burst
    bw = n_we;
    sel_low();
    check("wr_oe", MISO_OE, 1'b1);
    spi_byte(8'h02, 8, r0); spi_byte(8'h10, 8, r1);
    spi_byte(8'h55, 8, r2); spi_byte(8'hAA, 8, r3);
    sel_high();
    check("wr_miso0", r0, 8'h00); check("wr_miso1", r1, 8'h00);
    check("wr_miso2", r2, 8'h00); check("wr_miso3", r3, 8'h00);
    check("wr_count", n_we - bw, 2);
    check("wr_a0", we_addr[bw], 8'h10);   check("wr_d0", we_data[bw], 8'h55);
    check("wr_a1", we_addr[bw+1], 8'h11); check("wr_d1", we_data[bw+1], 8'hAA);
    check("wr_oe_off", MISO_OE, 1'b0);
    check("wr_miso_idle", MISO, 1'b1);

    // Read burst
    br = n_rd;
    sel_low();
    spi_byte(8'h03, 8, r0); spi_byte(8'h20, 8, r1);
    spi_byte(8'h00, 8, r2); spi_byte(8'h00, 8, r3);
    sel_high();
    check("rd_miso0", r0, 8'h00); check("rd_miso1", r1, 8'h00);
    check("rd_miso2", r2, 8'h3C); check("rd_miso3", r3, 8'h81);
    check("rd_a0", rd_addr[br], 8'h20); check("rd_a1", rd_addr[br+1], 8'h21);

    // Read wrap
    br = n_rd;
    sel_low();
    spi_byte(8'h03, 8, r0); spi_byte(8'hFF, 8, r1);
    spi_byte(8'h00, 8, r2); spi_byte(8'h00, 8, r3);
    sel_high();
    check("rwrap_miso2", r2, 8'h5A); check("rwrap_miso3", r3, 8'hA5);
    check("rwrap_a0", rd_addr[br], 8'hFF); check("rwrap_a1", rd_addr[br+1], 8'h00);

    // Write wrap
    bw = n_we;
    sel_low();
    spi_byte(8'h02, 8, r0); spi_byte(8'hFF, 8, r1);
    spi_byte(8'h11, 8, r2); spi_byte(8'h22, 8, r3);
    sel_high();
    check("wwrap_count", n_we - bw, 2);
    check("wwrap_a0", we_addr[bw], 8'hFF);   check("wwrap_d0", we_data[bw], 8'h11);
    check("wwrap_a1", we_addr[bw+1], 8'h00); check("wwrap_d1", we_data[bw+1], 8'h22);

    // Abort on partial byte, then a clean write
    bw = n_we;
    sel_low();
    spi_byte(8'h02, 8, r0); spi_byte(8'h40, 8, r1); spi_byte(8'hC3, 5, r2);
    sel_high();
    check("abort_no_we", n_we - bw, 0);
    sel_low();
    spi_byte(8'h02, 8, r0); spi_byte(8'h40, 8, r1); spi_byte(8'h77, 8, r2);
    sel_high();
    check("abort_we_count", n_we - bw, 1);
    check("abort_a", we_addr[bw], 8'h40); check("abort_d", we_data[bw], 8'h77);

    // Unknown command
    bw = n_we; br = n_rd;
    sel_low();
    spi_byte(8'h7E, 8, r0); spi_byte(8'h12, 8, r1); spi_byte(8'h34, 8, r2);
    sel_high();
    check("unk_miso1", r1, 8'hFF); check("unk_miso2", r2, 8'hFF);
    check("unk_strobes", (n_we - bw) + (n_rd - br), 0);

    // ID command
    bw = n_we; br = n_rd;
    sel_low();
    spi_byte(8'h9F, 8, r0); spi_byte(8'h00, 8, r1);
    spi_byte(8'h00, 8, r2); spi_byte(8'h00, 8, r3);
    sel_high();
`ifdef SPI_RESP_ID_EN
    check("id_b0", r1, 8'hC5); check("id_b1", r2, 8'h01); check("id_b2", r3, 8'h00);
`else
    check("id_b0", r1, 8'hFF); check("id_b1", r2, 8'hFF); check("id_b2", r3, 8'hFF);
`endif
    check("id_strobes", (n_we - bw) + (n_rd - br), 0);

    // Reset in the middle of a write-data byte with nSS held low
    bw = n_we;
    sel_low();
    spi_byte(8'h02, 8, r0); spi_byte(8'h30, 8, r1); spi_byte(8'h44, 3, r2);
    @(negedge CLK); nRESET = 1'b0;
    repeat (2) @(negedge CLK); nRESET = 1'b1;
    spi_byte(8'h44, 8, r2); spi_byte(8'h45, 8, r3);
    check("rstmid_miso", r3, 8'hFF);
    sel_high();
    check("rstmid_no_we", n_we - bw, 0);
    sel_low();
    spi_byte(8'h02, 8, r0); spi_byte(8'h05, 8, r1); spi_byte(8'h99, 8, r2);
    sel_high();
    check("rstmid_we_count", n_we - bw, 1);
    check("rstmid_a", we_addr[bw], 8'h05); check("rstmid_d", we_data[bw], 8'h99);

    check("we_rd_overlap", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
